// File: rtl/uart_pkg.sv
// Shared constants, state encoding and helpers for the UART transmit-side blocks.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Bits needed to count 0..value-1; never below one so tiny ranges still get a port.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: first set request at or above base, wrapping N-1 -> 0.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  logic found;
  int   pos;

  // Scan upward from base; wrap is explicit so non-power-of-two N works.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = 0;
    for (int i = 0; i < N; i++) begin
      pos = int'(base) + i;
      if (pos >= N) pos = pos - N;
      if (!found && req[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter sharing one tx FIFO write port among N requesters.
// A grant is held until the owner's last byte; length and stall watchdogs force release.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_LEN   = 256,
  parameter int STALL_CYC = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        req,
  input  logic [BYTE_W*N-1:0] req_data,
  input  logic [N-1:0]        req_last,
  output logic [N-1:0]        req_ack,
  output logic                tx_fifo_we,
  output logic [BYTE_W-1:0]   tx_fifo_wr_data,
  input  logic                tx_fifo_full,
  output logic [N-1:0]        grant,
  output logic                busy,
  output logic                trunc
);

  localparam int IW = clog2(N);
  localparam int BW = clog2(MAX_LEN);
  localparam int SW = clog2(STALL_CYC);

  localparam logic [IW-1:0] LAST_IDX    = IW'(N - 1);
  localparam logic [BW-1:0] LEN_LIMIT   = BW'(MAX_LEN - 1);
  localparam logic [SW-1:0] STALL_LIMIT = SW'(STALL_CYC - 1);

  state_t        state, state_nx;
  logic [IW-1:0] rr_ptr, owner, pick_idx;
  logic [N-1:0]  pick_onehot;
  logic [BW-1:0] byte_cnt;
  logic [SW-1:0] stall_cnt;
  logic          owner_req, owner_last, accept, release_now, force_rel;

  uart_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req    (req),
    .base   (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  // Select the owner's request, last flag and byte; decide whether a byte moves this cycle.
  always_comb begin
    owner_req       = 1'b0;
    owner_last      = 1'b0;
    tx_fifo_wr_data = '0;
    for (int i = 0; i < N; i++) begin
      if (owner == IW'(i)) begin
        owner_req       = req[i];
        owner_last      = req_last[i];
        tx_fifo_wr_data = req_data[i*BYTE_W +: BYTE_W];
      end
    end
    accept = (state == ST_SEND) && owner_req && !tx_fifo_full;
  end

  // grant is cleared asynchronously by reset, so ack and write drop at once.
  assign tx_fifo_we = accept;
  assign req_ack    = grant & {N{accept}};
  assign busy       = (state == ST_SEND);

  // Next state and release decisions: last byte, length watchdog, stall watchdog.
  always_comb begin
    state_nx    = state;
    release_now = 1'b0;
    force_rel   = 1'b0;
    case (state)
      ST_IDLE: if (|req) state_nx = ST_SEND;
      ST_SEND: begin
        if (accept) begin
          if (owner_last) begin
            release_now = 1'b1;
          end else if (byte_cnt == LEN_LIMIT) begin
            release_now = 1'b1;
            force_rel   = 1'b1;
          end
        end else if (!owner_req && stall_cnt == STALL_LIMIT) begin
          release_now = 1'b1;
          force_rel   = 1'b1;
        end
        if (release_now) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values together.
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Grant, owner index, round-robin pointer, byte/stall counters and truncation pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant     <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      byte_cnt  <= '0;
      stall_cnt <= '0;
      trunc     <= 1'b0;
    end else begin
      trunc <= force_rel;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant     <= pick_onehot;
            owner     <= pick_idx;
            byte_cnt  <= '0;
            stall_cnt <= '0;
          end
        end
        ST_SEND: begin
          if (release_now) begin
            grant  <= '0;
            rr_ptr <= (owner == LAST_IDX) ? '0 : owner + IW'(1);
          end else if (accept) begin
            byte_cnt  <= byte_cnt + BW'(1);
            stall_cnt <= '0;
          end else if (!owner_req && stall_cnt != STALL_LIMIT) begin
            // Backpressure with req high holds the counter; only an absent owner counts.
            stall_cnt <= stall_cnt + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Packet-level round-robin arbiter that shares one UART transmit FIFO write port (8-bit `we`/`wr_data`/`full`) among N byte-stream requesters. Sits between the requesters (console, debug monitor, status reporter) and the tx FIFO write side of the UART top. A grant is held until the owner's last byte, so packets are never interleaved. A length watchdog and a stall timeout stop a misbehaving requester from owning the UART forever.

## Interface
- `N`, 4: number of requesters, 2..8.
- `MAX_LEN`, 256: maximum accepted bytes per grant before a forced release, 2..4096.
- `STALL_CYC`, 1024: consecutive cycles the owner may hold `req` low mid-packet before a forced release, 2..65535.

- `clk` in 1: bus clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in N: requester i presents a valid byte.
- `req_data` in 8*N: requester i's byte on bits [8i+7:8i].
- `req_last` in N: requester i's byte is the final byte of its packet.
- `req_ack` out N: requester i's byte is accepted this cycle. Combinational.
- `tx_fifo_we` out 1: write strobe to the tx FIFO. Combinational.
- `tx_fifo_wr_data` out 8: byte to the tx FIFO, taken from the owner. Combinational.
- `tx_fifo_full` in 1: tx FIFO full flag.
- `grant` out N: one-hot owner; zero when idle. Registered.
- `busy` out 1: a grant is active. Registered.
- `trunc` out 1: one-cycle pulse on a forced release. Registered.

## Operation
- The state machine has two states, IDLE and SEND.
- IDLE:
  - `grant` = 0 and `tx_fifo_we` = 0.
  - If any `req` bit is set, select the first set bit at or after `rr_ptr`, scanning upward and wrapping from N-1 to 0.
  - Next cycle: `grant` holds that one-hot, `busy` = 1, state = SEND. Clear `byte_cnt` and `stall_cnt`.
- SEND, with owner g:
  - Accept = `req[g] & !tx_fifo_full`.
  - `tx_fifo_we` = accept, `req_ack[g]` = accept, `tx_fifo_wr_data` = `req_data[g]`.
  - Non-owners never see `req_ack` and are ignored.
  - On accept: `byte_cnt` increments and `stall_cnt` clears.
  - While `req[g]` = 0: `stall_cnt` increments and saturates.
  - While `tx_fifo_full` is set with `req[g]` = 1: `stall_cnt` holds, because backpressure is not a stall.
- Release conditions, evaluated in SEND. In every case: next state = IDLE, `grant` = 0, `busy` = 0, `rr_ptr` = (g+1) mod N.
  - (a) An accepted byte has `req_last[g]` set: normal release.
  - (b) An accepted byte is the MAX_LEN-th (`byte_cnt` == MAX_LEN-1 before the increment) and `req_last[g]` = 0: forced release, `trunc` pulses.
  - (c) `stall_cnt` reaches STALL_CYC-1 while `req[g]` = 0: forced release, no byte written, `trunc` pulses.
- Boundary cases:
  - Last byte coincides with the MAX_LEN-th byte: normal release, no `trunc`.
  - Owner raises `req` on the same cycle that the stall limit is reached: the byte is accepted when the FIFO has room, and no stall release occurs.
  - After a forced release, the truncated requester re-arbitrates like any other requester. Its remaining bytes form a new packet.
  - `rr_ptr` advances only on release and never in IDLE. A requester with a pending `req` is therefore granted within N grants.
- `req` and `req_data` must be stable until acked. The block does not check this.

## Timing
- Grant latency: `req` rises in IDLE at cycle t, `grant` is valid at t+1, and the first accept can occur at t+1.
- Throughput is one byte per cycle in SEND while the FIFO is not full.
- There is exactly one IDLE bubble cycle between consecutive packets.
- `tx_fifo_full` is sampled in the same cycle as `we`, so the block never writes while full and never causes a FIFO overflow.
- `trunc` is high for the single cycle after the release edge.
- Reset, asynchronous at any time including mid-packet, clears all of the following:
  - state = IDLE;
  - `grant`, `busy`, `trunc`, `rr_ptr`, `byte_cnt` and `stall_cnt` = 0;
  - `req_ack` and `tx_fifo_we` immediately low.
- After reset deassertion, arbitration starts from requester 0.
- Counter widths:
  - `byte_cnt` is clog2(MAX_LEN) bits;
  - `stall_cnt` is clog2(STALL_CYC) bits;
  - `rr_ptr` is clog2(N) bits, with wrap computed explicitly for N that is not a power of two.

## Structure
- Shared package `uart_pkg`:
  - state localparams `ST_IDLE` = 0 and `ST_SEND` = 1;
  - the `clog2` constant function;
  - the byte width constant 8.
- Sub-module `uart_rr_pick`: combinational rotating-priority picker. Inputs `req[N]` and `base`. Outputs a one-hot result and an index. It is instantiated once.
- The top holds the state register, counters and data mux.

## Test plan
- N=4, requesters 1 and 3 each send a 3-byte packet at the same time after reset. Required response:
  - requester 1 is granted first, since `rr_ptr` = 0 scans to 1;
  - the FIFO receives bytes 1a,1b,1c, one bubble, then 3a,3b,3c;
  - `rr_ptr` = 0 at the end.
- Backpressure: hold `tx_fifo_full` for cycles 2–5 of a 4-byte packet. Required: no `we` while full, all 4 bytes arrive in order, and no `trunc`.
- MAX_LEN=4 with a 6-byte packet. Required:
  - bytes 1–4 are written, `trunc` pulses once, and the grant drops;
  - the remaining 2 bytes go out under a new grant.
- A 4-byte packet ending on the MAX_LEN-th byte (MAX_LEN=4). Required: `trunc` stays 0.
- STALL_CYC=8: the owner drops `req` after 1 byte. Required: release and `trunc` after 8 cycles, and the other pending requester is granted next.
- Assert `reset` mid-packet. Required: `we`, `grant` and `busy` go to 0 at once, and after reset the first grant goes to the lowest-index requester.
